// File: rtl/rvm_mem_responder_pkg.sv
// Shared types and codes for the memory-bus responder.
package rvm_mem_responder_pkg;

    typedef enum logic [0:0] {
        RVM_MEMR_IDLE = 1'b0,
        RVM_MEMR_BUSY = 1'b1
    } memr_state_e;

    localparam logic [3:0] RVM_MEM_BEN_READ = 4'b0000;

endpackage

// File: rtl/rvm_sram.sv
// DEPTH x 32 RAM, four byte-lane write enables, registered read port.
module rvm_sram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic [3:0]                 we_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [31:0]                wdata_i,
    output logic [31:0]                rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Array is never cleared by reset; the caller gates en_i with reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

    logic unused_aw;
    assign unused_aw = (AW == 0);

endmodule

// File: rtl/rvm_mem_responder.sv
// Bus responder: word RAM with programmable wait states and error response.
module rvm_mem_responder
    import rvm_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic        mem_c_en,
    input  logic [3:0]  mem_b_en,
    output logic        mem_error,
    output logic        mem_stall
);

    localparam int unsigned AW = $clog2(DEPTH);

    memr_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;
    logic        accept;
    logic        done;
    logic        stall;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          addr_err;
    logic [3:0]    sram_we;
    logic [31:0]   sram_rdata;

    // Addresses below BASE_ADDR wrap to large offsets and fail the range check.
    assign off      = mem_addr - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign addr_err = (off[1:0] != 2'b00)
                   || ({2'b00, off[31:2]} >= 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        accept  = 1'b0;
        done    = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            RVM_MEMR_IDLE: begin
                stall = mem_c_en;
                if (mem_c_en) begin
                    accept  = 1'b1;
                    err_d   = addr_err;
                    rd_d    = !addr_err
                           && (mem_b_en == RVM_MEM_BEN_READ);
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = RVM_MEMR_BUSY;
                end
            end
            RVM_MEMR_BUSY: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done    = 1'b1;
                    state_d = RVM_MEMR_IDLE;
                end
            end
        endcase
        if (reset) begin
            stall  = 1'b0;
            done   = 1'b0;
            accept = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RVM_MEMR_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign sram_we = (accept && !addr_err) ? mem_b_en : 4'b0000;

    rvm_sram #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk     (clk),
        .reset   (reset),
        .en_i    (accept),
        .we_i    (sram_we),
        .addr_i  (idx),
        .wdata_i (mem_wdata),
        .rdata_o (sram_rdata)
    );

    assign mem_stall = stall;
    assign mem_error = done & err_q;
    assign mem_rdata = (done && rd_q) ? sram_rdata : 32'h0;

endmodule
